// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the toggle-handshake receiver (and its future transmitter).
package toggle_hs_pkg;

  // Receiver FSM states, 1-bit encoded.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hs_state_e;

  // Default synchroniser depth, shared by both ends of the handshake.
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage : toggle_hs_pkg

// File: rtl/toggle_hs_rx_if.sv
// Handshake bundle: toggle request/ack from the sender plus the valid/ready consumer port.
interface toggle_hs_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_tgl;
  logic [WIDTH-1:0] data_in;
  logic             ack_tgl;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  // Receiver side.
  modport slave (
    input  req_tgl, data_in, dout_ready,
    output dout, dout_valid, ack_tgl
  );

  // Environment side: sender and consumer.
  modport master (
    output req_tgl, data_in, dout_ready,
    input  dout, dout_valid, ack_tgl
  );
endinterface : toggle_hs_rx_if

// File: rtl/tgl_sync.sv
// Multi-flop synchroniser for a single toggle level; synchronous reset to 0.
// Depth is expected to be 2..4.
module tgl_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule : tgl_sync

// File: rtl/toggle_hs_rx.sv
// Receiver end of the two-phase toggle handshake: synchronises req_tgl, captures
// the sender word into a valid/ready port and returns an ack toggle once consumed.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no word pending; next request event captures data_in
//   ST_HOLD | word presented on dout, waiting for dout_ready
module toggle_hs_rx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  toggle_hs_rx_if.slave  hs,
  output logic           overrun_o
);

  logic             req_s;
  logic             req_prev_q;
  logic             evt;

  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             overrun_q, overrun_d;

  tgl_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (hs.req_tgl),
    .q_o (req_s)
  );

  // Any level change of the synchronised request is one transfer.
  assign evt = req_s ^ req_prev_q;

  // Remember last synchronised request level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev_q <= 1'b0;
    end else begin
      req_prev_q <= req_s;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ack_d     = ack_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          dout_d  = hs.data_in;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (valid_q && hs.dout_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = ST_IDLE;
        end
        // A request seen here is dropped even if the handshake completes this
        // cycle: the sender cannot have observed the ack yet.
        if (evt) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending word without acking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
    end
  end

  assign hs.dout       = dout_q;
  assign hs.dout_valid = valid_q;
  assign hs.ack_tgl    = ack_q;
  assign overrun_o     = overrun_q;

endmodule : toggle_hs_rx
